// File: rtl/branch_pred_unit_if.sv
// Fetch-lookup and EX-resolve signal bundle for the branch prediction unit.
// The master side drives the fetch PC and the resolving instruction; the
// slave side (the predictor) returns the prediction, next-PC select and
// statistics.
interface branch_pred_unit_if;
  logic [31:0] i_pc_f;
  logic        i_ex_valid;
  logic        i_ex_is_branch;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic [1:0]  o_pc_sel;
  logic        o_flush;
  logic [15:0] o_br_cnt;
  logic [15:0] o_mis_cnt;

  modport master (
    output i_pc_f, i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_taken,
           i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    input  o_pred_taken, o_pred_target, o_pc_sel, o_flush, o_br_cnt, o_mis_cnt
  );

  modport slave (
    input  i_pc_f, i_ex_valid, i_ex_is_branch, i_ex_pc, i_ex_taken,
           i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    output o_pred_taken, o_pred_target, o_pc_sel, o_flush, o_br_cnt, o_mis_cnt
  );
endinterface

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB with per-entry 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; training happens on the edge at
// which a control-flow instruction resolves in EX. Same-index lookup and
// update in one cycle sees the old contents (no bypass).
module branch_pred_unit #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  branch_pred_unit_if.slave bus
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];
  logic [15:0]      br_cnt_q;
  logic [15:0]      mis_cnt_q;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic             mispredict;
  logic             unused_pc_lsbs;

  // Word-aligned PCs: the two low bits never take part in index or tag.
  assign unused_pc_lsbs = ^{bus.i_pc_f[1:0], bus.i_ex_pc[1:0]};

  function automatic logic [1:0] ctr_up(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_down(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  // Fetch lookup, EX mispredict detection and next-PC select.
  always_comb begin
    f_idx = bus.i_pc_f[IDX_W+1:2];
    f_tag = bus.i_pc_f[31:IDX_W+2];
    e_idx = bus.i_ex_pc[IDX_W+1:2];
    e_tag = bus.i_ex_pc[31:IDX_W+2];
    f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    bus.o_pred_taken  = f_hit & ctr_q[f_idx][1];
    bus.o_pred_target = f_hit ? tgt_q[f_idx] : 32'h0;

    mispredict = bus.i_ex_valid &
                 ((bus.i_ex_pred_taken != bus.i_ex_taken) |
                  (bus.i_ex_taken & (bus.i_ex_pred_target != bus.i_ex_target)));
    bus.o_flush = mispredict;

    bus.o_pc_sel = 2'd0;
    if (mispredict && bus.i_ex_taken)       bus.o_pc_sel = 2'd2;
    else if (mispredict)                    bus.o_pc_sel = 2'd3;
    else if (bus.o_pred_taken)              bus.o_pc_sel = 2'd1;

    bus.o_br_cnt  = br_cnt_q;
    bus.o_mis_cnt = mis_cnt_q;
  end

  // Table training: jumps always (re)allocate strongly taken; branches train
  // on hit and allocate weakly taken only when a miss turns out taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= 32'h0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (bus.i_ex_valid) begin
      if (!bus.i_ex_is_branch) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
        tgt_q[e_idx]   <= bus.i_ex_target;
        ctr_q[e_idx]   <= 2'b11;
      end else if (e_hit) begin
        ctr_q[e_idx] <= bus.i_ex_taken ? ctr_up(ctr_q[e_idx]) : ctr_down(ctr_q[e_idx]);
        if (bus.i_ex_taken) tgt_q[e_idx] <= bus.i_ex_target;
      end else if (bus.i_ex_taken) begin
        valid_q[e_idx] <= 1'b1;
        tag_q[e_idx]   <= e_tag;
        tgt_q[e_idx]   <= bus.i_ex_target;
        ctr_q[e_idx]   <= 2'b10;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      br_cnt_q  <= 16'h0;
      mis_cnt_q <= 16'h0;
    end else begin
      if (bus.i_ex_valid) br_cnt_q  <= sat_inc16(br_cnt_q);
      if (mispredict)     mis_cnt_q <= sat_inc16(mis_cnt_q);
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed bench for branch_pred_unit: a vector table walks allocation,
// training, aliasing, jumps and same-cycle lookup/update; hand-written
// sequences cover reset behaviour and counter saturation.
module tb_branch_pred_unit;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  branch_pred_unit_if bus ();

  branch_pred_unit #(.ENTRIES(16), .IDX_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_f;
    logic        ex_valid;
    logic        is_branch;
    logic [31:0] ex_pc;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        exp_pt;
    logic [31:0] exp_tgt;
    logic [1:0]  exp_sel;
    logic        exp_flush;
    logic [15:0] exp_br;
    logic [15:0] exp_mis;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] pc_f, input logic v, input logic br,
                       input logic [31:0] epc, input logic tk, input logic [31:0] tg,
                       input logic ptk, input logic [31:0] ptg);
    bus.i_pc_f           = pc_f;
    bus.i_ex_valid       = v;
    bus.i_ex_is_branch   = br;
    bus.i_ex_pc          = epc;
    bus.i_ex_taken       = tk;
    bus.i_ex_target      = tg;
    bus.i_ex_pred_taken  = ptk;
    bus.i_ex_pred_target = ptg;
  endtask

  function automatic vec_t mk(logic [31:0] pc_f, logic v, logic br, logic [31:0] epc,
                              logic tk, logic [31:0] tg, logic ptk, logic [31:0] ptg,
                              logic ept, logic [31:0] etg, logic [1:0] esel, logic efl,
                              logic [15:0] ebr, logic [15:0] emis);
    vec_t r;
    r.pc_f = pc_f; r.ex_valid = v; r.is_branch = br; r.ex_pc = epc;
    r.taken = tk; r.target = tg; r.pred_taken = ptk; r.pred_target = ptg;
    r.exp_pt = ept; r.exp_tgt = etg; r.exp_sel = esel; r.exp_flush = efl;
    r.exp_br = ebr; r.exp_mis = emis;
    return r;
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;

    //            pc_f    v  br ex_pc   tk target  ptk ptgt    | pt tgt    sel fl br mis
    vecs[0]  = mk(32'h100,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    vecs[1]  = mk(32'h100,1, 1, 32'h100,1, 32'h200,0, 32'h0,   0, 32'h0,   2, 1, 1, 1);
    vecs[2]  = mk(32'h100,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   1, 32'h200, 1, 0, 1, 1);
    vecs[3]  = mk(32'h100,1, 1, 32'h100,0, 32'h104,1, 32'h200, 1, 32'h200, 3, 1, 2, 2);
    vecs[4]  = mk(32'h100,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   0, 32'h200, 0, 0, 2, 2);
    vecs[5]  = mk(32'h100,1, 1, 32'h100,0, 32'h104,0, 32'h0,   0, 32'h200, 0, 0, 3, 2);
    vecs[6]  = mk(32'h100,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   0, 32'h200, 0, 0, 3, 2);
    vecs[7]  = mk(32'h100,1, 1, 32'h100,1, 32'h200,0, 32'h0,   0, 32'h200, 2, 1, 4, 3);
    vecs[8]  = mk(32'h100,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   0, 32'h200, 0, 0, 4, 3);
    vecs[9]  = mk(32'h140,1, 1, 32'h140,1, 32'h300,0, 32'h0,   0, 32'h0,   2, 1, 5, 4);
    vecs[10] = mk(32'h100,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 5, 4);
    vecs[11] = mk(32'h140,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   1, 32'h300, 1, 0, 5, 4);
    vecs[12] = mk(32'h108,1, 0, 32'h108,1, 32'h400,0, 32'h0,   0, 32'h0,   2, 1, 6, 5);
    vecs[13] = mk(32'h108,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   1, 32'h400, 1, 0, 6, 5);
    vecs[14] = mk(32'h108,1, 0, 32'h108,1, 32'h400,1, 32'h400, 1, 32'h400, 1, 0, 7, 5);
    vecs[15] = mk(32'h140,1, 0, 32'h108,1, 32'h500,1, 32'h400, 1, 32'h300, 2, 1, 8, 6);
    vecs[16] = mk(32'h108,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   1, 32'h500, 1, 0, 8, 6);
    vecs[17] = mk(32'h140,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   1, 32'h300, 1, 0, 8, 6);
    vecs[18] = mk(32'h100,1, 1, 32'h100,1, 32'h600,0, 32'h0,   0, 32'h0,   2, 1, 9, 7);
    vecs[19] = mk(32'h100,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   1, 32'h600, 1, 0, 9, 7);
    vecs[20] = mk(32'h10C,1, 1, 32'h10C,0, 32'h800,0, 32'h0,   0, 32'h0,   0, 0, 10, 7);
    vecs[21] = mk(32'h10C,0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 0, 10, 7);

    // Cold reset.
    rst_n = 1'b0;
    drive(32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_br_cnt", {16'h0, bus.o_br_cnt}, 32'h0);
    check("reset_mis_cnt", {16'h0, bus.o_mis_cnt}, 32'h0);

    // Table-driven vectors: combinational outputs before the edge, counters after.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].pc_f, vecs[i].ex_valid, vecs[i].is_branch, vecs[i].ex_pc,
            vecs[i].taken, vecs[i].target, vecs[i].pred_taken, vecs[i].pred_target);
      #2;
      check($sformatf("v%0d_pred_taken", i), {31'h0, bus.o_pred_taken}, {31'h0, vecs[i].exp_pt});
      check($sformatf("v%0d_pred_target", i), bus.o_pred_target, vecs[i].exp_tgt);
      check($sformatf("v%0d_pc_sel", i), {30'h0, bus.o_pc_sel}, {30'h0, vecs[i].exp_sel});
      check($sformatf("v%0d_flush", i), {31'h0, bus.o_flush}, {31'h0, vecs[i].exp_flush});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_br_cnt", i), {16'h0, bus.o_br_cnt}, {16'h0, vecs[i].exp_br});
      check($sformatf("v%0d_mis_cnt", i), {16'h0, bus.o_mis_cnt}, {16'h0, vecs[i].exp_mis});
    end

    // Reset with a pending mispredict: outputs stay combinational, no update or count.
    rst_n = 1'b0;
    drive(32'h140, 1, 1, 32'h140, 1, 32'h700, 0, 32'h0);
    #2;
    check("rst_flush_comb", {31'h0, bus.o_flush}, 32'h1);
    check("rst_pc_sel_comb", {30'h0, bus.o_pc_sel}, 32'h2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(32'h140, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #2;
    check("post_rst_br_cnt", {16'h0, bus.o_br_cnt}, 32'h0);
    check("post_rst_mis_cnt", {16'h0, bus.o_mis_cnt}, 32'h0);
    check("post_rst_140_pt", {31'h0, bus.o_pred_taken}, 32'h0);
    check("post_rst_140_tgt", bus.o_pred_target, 32'h0);
    check("post_rst_140_sel", {30'h0, bus.o_pc_sel}, 32'h0);
    bus.i_pc_f = 32'h108;
    #1;
    check("post_rst_108_tgt", bus.o_pred_target, 32'h0);
    @(posedge clk);
    #1;

    // Drive 65535 mispredicts, then one more: both counters pinned at 0xFFFF.
    drive(32'h0, 1, 1, 32'h200, 1, 32'h900, 0, 32'h0);
    repeat (65535) @(posedge clk);
    #1;
    check("sat_mis_preload", {16'h0, bus.o_mis_cnt}, 32'hFFFF);
    check("sat_br_preload", {16'h0, bus.o_br_cnt}, 32'hFFFF);
    @(posedge clk);
    #1;
    check("sat_mis_hold", {16'h0, bus.o_mis_cnt}, 32'hFFFF);
    check("sat_br_hold", {16'h0, bus.o_br_cnt}, 32'hFFFF);
    bus.i_ex_valid = 1'b0;
    bus.i_pc_f     = 32'h200;
    #1;
    check("sat_200_hit_pt", {31'h0, bus.o_pred_taken}, 32'h1);

    // One-edge reset mid-operation with an update pending.
    rst_n = 1'b0;
    bus.i_ex_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_ex_valid = 1'b0;
    #1;
    check("sat_rst_mis_cnt", {16'h0, bus.o_mis_cnt}, 32'h0);
    check("sat_rst_br_cnt", {16'h0, bus.o_br_cnt}, 32'h0);
    check("sat_rst_200_pt", {31'h0, bus.o_pred_taken}, 32'h0);
    check("sat_rst_200_tgt", bus.o_pred_target, 32'h0);
    check("sat_rst_200_sel", {30'h0, bus.o_pc_sel}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
